// File: rtl/ice_slave_arbiter.sv
// Slave-return arbiter: grants one of NUM_DEV devices the sl_data bus, buffers latched bytes
// in a FIFO toward the UART TX path. Define ICE_ARB_STATS_EN to build the frame/drop counters.
module ice_slave_arbiter #(
  parameter int NUM_DEV   = 8,
  parameter int FIFO_AW   = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_rr_mode,
  input  logic [NUM_DEV-1:0]         cfg_dev_mask,
  input  logic [TIMEOUT_W-1:0]       cfg_timeout,
  input  logic [NUM_DEV-1:0]         sl_arb_request,
  output logic [NUM_DEV-1:0]         sl_arb_grant,
  input  logic [7:0]                 sl_data,
  input  logic                       sl_data_latch,
  output logic                       sl_overflow,
  output logic [$clog2(NUM_DEV)-1:0] grant_id,
  output logic                       busy,
  output logic                       frame_abort,
  output logic                       drop_err,
  output logic [7:0]                 tx_char,
  output logic                       tx_char_valid,
  input  logic                       tx_char_ready,
  output logic [15:0]                stat_frames,
  output logic [7:0]                 stat_drops
);

  localparam int ID_W  = $clog2(NUM_DEV);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [NUM_DEV-1:0]   lockout_q, lockout_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 frame_abort_q, frame_abort_d;
  logic                 drop_err_q;
  logic [NUM_DEV-1:0]   eligible;
  logic [ID_W-1:0]      winner, scan_idx;
  logic                 found;

  assign eligible = sl_arb_request & cfg_dev_mask & ~lockout_q;
  assign wd_inc   = wd_q + TIMEOUT_W'(1);

  // Round-robin scans upward from the slot after the previous winner.
  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (cfg_rr_mode) begin
      for (int k = 1; k <= NUM_DEV; k++) begin
        scan_idx = ID_W'((int'(grant_id_q) + k) % NUM_DEV);
        if (!found && eligible[scan_idx]) begin
          found  = 1'b1;
          winner = scan_idx;
        end
      end
    end else begin
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
        scan_idx = ID_W'(i);
        if (eligible[scan_idx]) begin
          found  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    wd_d          = wd_q;
    lockout_d     = lockout_q & sl_arb_request;
    frame_abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (found) begin
          grant_id_d = winner;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        // A normal end takes priority over a watchdog expiry in the same cycle.
        if (!sl_arb_request[grant_id_q]) begin
          state_d = S_RELEASE;
        end else if (sl_data_latch) begin
          wd_d = '0;
        end else if (cfg_timeout != '0 && wd_inc == cfg_timeout) begin
          frame_abort_d         = 1'b1;
          lockout_d[grant_id_q] = 1'b1;
          state_d               = S_RELEASE;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_id_q    <= ID_W'(NUM_DEV - 1);
      lockout_q     <= '0;
      wd_q          <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      lockout_q     <= lockout_d;
      wd_q          <= wd_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    sl_arb_grant = '0;
    if (state_q == S_GRANT) sl_arb_grant[grant_id_q] = 1'b1;
  end

  assign grant_id    = grant_id_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_abort = frame_abort_q;

  // Return FIFO
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               full, empty, latch_ok, push, pop, drop;

  assign full     = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign latch_ok = (state_q == S_GRANT) && sl_data_latch;
  assign pop      = !empty && tx_char_ready;
  assign push     = latch_ok && (!full || pop);
  assign drop     = latch_ok && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      drop_err_q <= drop;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count_q, so stale bytes are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sl_data;
  end

  assign tx_char       = mem_q[rd_ptr_q];
  assign tx_char_valid = !empty;
  assign sl_overflow   = full;
  assign drop_err      = drop_err_q;

`ifdef ICE_ARB_STATS_EN
  logic [15:0] frames_q;
  logic [7:0]  drops_q;
  logic        frame_done;

  assign frame_done = (state_q == S_GRANT) && !sl_arb_request[grant_id_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (frame_done)                frames_q <= frames_q + 16'd1;
      if (drop && drops_q != 8'hFF) drops_q  <= drops_q + 8'd1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_drops  = drops_q;
`else
  assign stat_frames = '0;
  assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_ice_slave_arbiter.sv
// Self-checking bench for ice_slave_arbiter: per-feature tasks, byte scoreboard for the FIFO path.
module tb_ice_slave_arbiter;

  localparam int NUM_DEV   = 8;
  localparam int FIFO_AW   = 4;
  localparam int TIMEOUT_W = 16;
  localparam int DEPTH     = 16;
`ifdef ICE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_rr_mode;
  logic [NUM_DEV-1:0]   cfg_dev_mask;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic [NUM_DEV-1:0]   sl_arb_request;
  logic [NUM_DEV-1:0]   sl_arb_grant;
  logic [7:0]           sl_data;
  logic                 sl_data_latch;
  logic                 sl_overflow;
  logic [2:0]           grant_id;
  logic                 busy, frame_abort, drop_err;
  logic [7:0]           tx_char;
  logic                 tx_char_valid, tx_char_ready;
  logic [15:0]          stat_frames;
  logic [7:0]           stat_drops;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] sb_q[$];

  ice_slave_arbiter #(.NUM_DEV(NUM_DEV), .FIFO_AW(FIFO_AW), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .reset(reset), .cfg_rr_mode(cfg_rr_mode), .cfg_dev_mask(cfg_dev_mask),
    .cfg_timeout(cfg_timeout), .sl_arb_request(sl_arb_request), .sl_arb_grant(sl_arb_grant),
    .sl_data(sl_data), .sl_data_latch(sl_data_latch), .sl_overflow(sl_overflow),
    .grant_id(grant_id), .busy(busy), .frame_abort(frame_abort), .drop_err(drop_err),
    .tx_char(tx_char), .tx_char_valid(tx_char_valid), .tx_char_ready(tx_char_ready),
    .stat_frames(stat_frames), .stat_drops(stat_drops)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    cfg_rr_mode    = 1'b0;
    cfg_dev_mask   = 8'hFF;
    cfg_timeout    = '0;
    sl_arb_request = '0;
    sl_data        = '0;
    sl_data_latch  = 1'b0;
    tx_char_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    set_defaults();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    sb_q.delete();
  endtask

  // Pops the scoreboard for every byte the consumer accepts; bounded by a cycle budget.
  task automatic drain_and_check(input string tag);
    int budget = 64;
    logic [7:0] exp_b;
    tx_char_ready = 1'b1;
    while ((sb_q.size() != 0 || tx_char_valid) && budget > 0) begin
      if (tx_char_valid) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_extra_byte: got %h, expected no byte", tag, tx_char);
        end else begin
          exp_b = sb_q.pop_front();
          if (tx_char !== exp_b) begin
            tests_failed++;
            $display("FAIL %s_byte: got %h expected %h", tag, tx_char, exp_b);
          end
        end
      end
      tick();
      budget--;
    end
    tests_run++;
    if (budget == 0 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d bytes left, expected 0", tag, sb_q.size());
    end
    tx_char_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    reset = 1'b0;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_grant: grant %h busy %b expected 00 0", sl_arb_grant, busy);
    end
    tests_run++;
    if (grant_id !== 3'd7) begin
      tests_failed++;
      $display("FAIL reset_grant_id: got %0d expected 7", grant_id);
    end
    tests_run++;
    if ({sl_overflow, tx_char_valid, frame_abort, drop_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000",
               {sl_overflow, tx_char_valid, frame_abort, drop_err});
    end
    tests_run++;
    if (stat_frames !== 16'd0 || stat_drops !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_frames, stat_drops);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fixed_priority();
    sl_arb_request = 8'b0110;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0010 || grant_id !== 3'd1) begin
      tests_failed++;
      $display("FAIL fixed_first: grant %b id %0d expected 00000010 1", sl_arb_grant, grant_id);
    end
    sl_arb_request = 8'b0100;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fixed_release: grant %b busy %b expected 0 1", sl_arb_grant, busy);
    end
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fixed_idle_gap: grant %b busy %b expected 0 0", sl_arb_grant, busy);
    end
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0100 || grant_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL fixed_second: grant %b id %0d expected 00000100 2", sl_arb_grant, grant_id);
    end
    sl_arb_request = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 3, 0, 3};
    logic [7:0] exp_g;
    apply_reset();
    cfg_rr_mode    = 1'b1;
    sl_arb_request = 8'b1001;
    for (int f = 0; f < 4; f++) begin
      tick();
      exp_g = 8'(1 << order[f]);
      tests_run++;
      if (sl_arb_grant !== exp_g || grant_id !== 3'(order[f])) begin
        tests_failed++;
        $display("FAIL rr_frame%0d: grant %b id %0d expected %b %0d",
                 f, sl_arb_grant, grant_id, exp_g, order[f]);
      end
      sl_arb_request = 8'b1001 & ~exp_g;
      tick();
      sl_arb_request = 8'b1001;
      tick();
    end
    sl_arb_request = '0;
    cfg_rr_mode    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fifo_overflow();
    sl_arb_request = 8'b0001;
    tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      sl_data       = 8'(i);
      sl_data_latch = 1'b1;
      if (i < DEPTH) sb_q.push_back(8'(i));
      tick();
      if (i == DEPTH - 2) begin
        tests_run++;
        if (sl_overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_early: overflow %b after 15 latches expected 0", sl_overflow);
        end
      end
      if (i == DEPTH - 1) begin
        tests_run++;
        if (sl_overflow !== 1'b1 || drop_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_full: overflow %b drop %b expected 1 0", sl_overflow, drop_err);
        end
      end
    end
    sl_data_latch = 1'b0;
    tests_run++;
    if (drop_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_drop: drop_err %b expected 1", drop_err);
    end
    tick();
    tests_run++;
    if (drop_err !== 1'b0 || stat_drops !== (STATS ? 8'd1 : 8'd0)) begin
      tests_failed++;
      $display("FAIL ovf_drop_pulse: drop_err %b drops %0d expected 0 %0d",
               drop_err, stat_drops, STATS ? 1 : 0);
    end
    drain_and_check("ovf");
    sl_arb_request = '0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    apply_reset();
    cfg_timeout    = 16'd5;
    sl_arb_request = 8'b0001;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0001) begin
      tests_failed++;
      $display("FAIL wd_grant: grant %b expected 00000001", sl_arb_grant);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (sl_arb_grant !== 8'b0001 || frame_abort !== 1'b0) begin
        tests_failed++;
        $display("FAIL wd_hold%0d: grant %b abort %b expected 1 0", c, sl_arb_grant, frame_abort);
      end
    end
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || frame_abort !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_abort: grant %b abort %b expected 0 1", sl_arb_grant, frame_abort);
    end
    sl_arb_request = 8'b0101;
    tick();
    tests_run++;
    if (frame_abort !== 1'b0 || stat_frames !== 16'd0) begin
      tests_failed++;
      $display("FAIL wd_abort_pulse: abort %b frames %0d expected 0 0", frame_abort, stat_frames);
    end
    tick();
    cfg_timeout = '0;
    tests_run++;
    if (sl_arb_grant !== 8'b0100) begin
      tests_failed++;
      $display("FAIL wd_second_dev: grant %b expected 00000100", sl_arb_grant);
    end
    sl_arb_request = 8'b0001;
    tick();
    tick();
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_lockout: grant %b busy %b expected 0 0", sl_arb_grant, busy);
    end
    sl_arb_request = '0;
    tick();
    sl_arb_request = 8'b0001;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0001) begin
      tests_failed++;
      $display("FAIL wd_unlock: grant %b expected 00000001", sl_arb_grant);
    end
    sl_arb_request = '0;
    tick();
    tick();
  endtask

  task automatic test_mask();
    cfg_dev_mask   = 8'b1110;
    sl_arb_request = 8'b0001;
    tick();
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_block: grant %b busy %b expected 0 0", sl_arb_grant, busy);
    end
    sl_data       = 8'h77;
    sl_data_latch = 1'b1;
    tick();
    sl_data_latch = 1'b0;
    tick();
    tests_run++;
    if (tx_char_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_latch_ignored: valid %b expected 0", tx_char_valid);
    end
    cfg_dev_mask = 8'hFF;
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0001) begin
      tests_failed++;
      $display("FAIL mask_enable: grant %b expected 00000001", sl_arb_grant);
    end
    cfg_dev_mask = 8'h00;
    tick();
    tick();
    tests_run++;
    if (sl_arb_grant !== 8'b0001) begin
      tests_failed++;
      $display("FAIL mask_hold: grant %b expected 00000001", sl_arb_grant);
    end
    cfg_dev_mask   = 8'hFF;
    sl_arb_request = '0;
    tick();
    tick();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_b;
    sl_arb_request = 8'b0001;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      sl_data       = 8'(8'h20 + i);
      sl_data_latch = 1'b1;
      sb_q.push_back(8'(8'h20 + i));
      tick();
    end
    tests_run++;
    if (sl_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL fp_full: overflow %b expected 1", sl_overflow);
    end
    sl_data       = 8'hAA;
    tx_char_ready = 1'b1;
    exp_b = sb_q.pop_front();
    tests_run++;
    if (tx_char !== exp_b) begin
      tests_failed++;
      $display("FAIL fp_head: got %h expected %h", tx_char, exp_b);
    end
    sb_q.push_back(8'hAA);
    tick();
    sl_data_latch = 1'b0;
    tests_run++;
    if (drop_err !== 1'b0 || sl_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL fp_accept: drop %b overflow %b expected 0 1", drop_err, sl_overflow);
    end
    drain_and_check("fp");
    sl_arb_request = '0;
    tick();
    tick();
  endtask

  task automatic test_stats();
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      sl_arb_request = 8'b0010;
      tick();
      sl_arb_request = '0;
      tick();
      tick();
    end
    tests_run++;
    if (stat_frames !== (STATS ? 16'd3 : 16'd0) || stat_drops !== 8'd0) begin
      tests_failed++;
      $display("FAIL stats_frames: frames %0d drops %0d expected %0d 0",
               stat_frames, stat_drops, STATS ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid_frame();
    sl_arb_request = 8'b0010;
    tick();
    sl_data_latch = 1'b1;
    sl_data       = 8'h5A;
    tick();
    sl_data       = 8'h5B;
    tick();
    sl_data_latch = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (sl_arb_grant !== 8'h00 || tx_char_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 3'd7) begin
      tests_failed++;
      $display("FAIL midreset: grant %b valid %b busy %b id %0d expected 0 0 0 7",
               sl_arb_grant, tx_char_valid, busy, grant_id);
    end
    set_defaults();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    set_defaults();
    reset = 1'b1;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_fifo_overflow();
    test_watchdog();
    test_mask();
    test_full_pop();
    test_stats();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
